// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Writeback sequencer for the 8-entry accumulator/register file.
// ALU results and data-memory loads are queued in program order and
// retired one per cycle onto the regfile write port (wen/acc_sel/wa/wd).
// A load reserves its queue slot at issue time and becomes ready when its
// data returns. Only one load may be outstanding at a time.
// Protocol violations set a sticky err flag that clears only on reset.

module regfile_wb_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic                 alu_to_rf,
    input  logic [AW-1:0]        alu_addr,
    input  logic [DW-1:0]        alu_data,
    input  logic                 mem_req,
    input  logic                 mem_to_rf,
    input  logic [AW-1:0]        mem_addr,
    input  logic                 mem_rdata_valid,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 wen,
    output logic                 acc_sel,
    output logic [AW-1:0]        wa,
    output logic [DW-1:0]        wd,
    output logic                 stall,
    output logic                 pending_acc,
    output logic [(1<<AW)-1:0]   pending_rf,
    output logic                 err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NR = 1 << AW;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};

    // ------------------------------------------------------------------
    // Queue storage and control state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]   q_valid_r;
    logic [DEPTH-1:0]   q_ready_r;
    logic [DEPTH-1:0]   q_to_rf_r;
    logic [AW-1:0]      q_addr_r [DEPTH];
    logic [DW-1:0]      q_data_r [DEPTH];

    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [CW-1:0]      count_r;
    logic               load_out_r;
    logic [PW-1:0]      load_ptr_r;
    logic               err_r;

    logic               wen_r;
    logic               acc_sel_r;
    logic [AW-1:0]      wa_r;
    logic [DW-1:0]      wd_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic               rdata_fire_s;
    logic               rdata_hits_head_s;
    logic               head_ready_s;
    logic               pop_s;
    logic               bypass_s;
    logic               space_s;
    logic               mem_try_s;
    logic               alu_acc_s;
    logic               mem_acc_s;
    logic               enq_s;
    logic               err_set_s;
    logic               retire_s;
    logic               ret_to_rf_s;
    logic [AW-1:0]      ret_addr_s;
    logic [DW-1:0]      ret_data_s;
    logic [CW-1:0]      count_next_s;
    logic               pending_acc_s;
    logic [NR-1:0]      pending_rf_s;

    // Push/pop arbitration: load completion, head readiness, space and errors
    always_comb begin
        rdata_fire_s      = mem_rdata_valid & load_out_r;
        rdata_hits_head_s = rdata_fire_s & (load_ptr_r == head_r);
        // Returning load data may make the head poppable in the same cycle.
        head_ready_s      = q_ready_r[head_r] | rdata_hits_head_s;
        pop_s             = (count_r != EMPTY_C) & head_ready_s;
        // An ALU result into an empty queue retires straight from the inputs.
        bypass_s          = (count_r == EMPTY_C) & alu_valid;
        space_s           = (count_r != FULL_C) | pop_s;
        // A same-cycle data return frees the load slot before the new request.
        mem_try_s         = mem_req & ~alu_valid & ~(load_out_r & ~mem_rdata_valid);
        alu_acc_s         = alu_valid & space_s;
        mem_acc_s         = mem_try_s & space_s;
        enq_s             = (alu_acc_s & ~bypass_s) | mem_acc_s;
        err_set_s         = (alu_valid & mem_req)
                          | (mem_req & load_out_r & ~mem_rdata_valid)
                          | (mem_rdata_valid & ~load_out_r)
                          | (alu_valid & ~space_s)
                          | (mem_try_s & ~space_s);
        count_next_s      = count_r + CW'(enq_s) - CW'(pop_s);
    end

    // Select the entry retiring this cycle (head of queue or bypassed ALU result)
    always_comb begin
        retire_s    = pop_s | bypass_s;
        ret_to_rf_s = 1'b0;
        ret_addr_s  = {AW{1'b0}};
        ret_data_s  = {DW{1'b0}};
        if (bypass_s) begin
            ret_to_rf_s = alu_to_rf;
            ret_addr_s  = alu_addr;
            ret_data_s  = alu_data;
        end else begin
            ret_to_rf_s = q_to_rf_r[head_r];
            ret_addr_s  = q_addr_r[head_r];
            ret_data_s  = rdata_hits_head_s ? mem_rdata : q_data_r[head_r];
        end
    end

    // Hazard flags decoded from registered queue entries only
    always_comb begin
        pending_acc_s = 1'b0;
        pending_rf_s  = {NR{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pending_acc_s = pending_acc_s | (q_valid_r[i] & ~q_to_rf_r[i]);
            for (int j = 0; j < NR; j++) begin
                pending_rf_s[j] = pending_rf_s[j]
                                | (q_valid_r[i] & q_to_rf_r[i] & (q_addr_r[i] == AW'(j)));
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Queue entry storage: load completion, then pop, then push (push wins on a shared slot)
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid_r <= {DEPTH{1'b0}};
            q_ready_r <= {DEPTH{1'b0}};
            q_to_rf_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= {AW{1'b0}};
                q_data_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (rdata_fire_s) begin
                q_data_r[load_ptr_r]  <= mem_rdata;
                q_ready_r[load_ptr_r] <= 1'b1;
            end
            if (pop_s) begin
                q_valid_r[head_r] <= 1'b0;
                q_ready_r[head_r] <= 1'b0;
            end
            if (enq_s) begin
                q_valid_r[tail_r] <= 1'b1;
                q_ready_r[tail_r] <= alu_acc_s;
                q_to_rf_r[tail_r] <= alu_acc_s ? alu_to_rf : mem_to_rf;
                q_addr_r[tail_r]  <= alu_acc_s ? alu_addr  : mem_addr;
                q_data_r[tail_r]  <= alu_acc_s ? alu_data  : {DW{1'b0}};
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= EMPTY_C;
        end else begin
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            if (enq_s) begin
                tail_r <= tail_r + PW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Outstanding-load tracking: a new reservation overrides a same-cycle completion
    always_ff @(posedge clk) begin
        if (reset) begin
            load_out_r <= 1'b0;
            load_ptr_r <= {PW{1'b0}};
        end else if (mem_acc_s) begin
            load_out_r <= 1'b1;
            load_ptr_r <= tail_r;
        end else if (rdata_fire_s) begin
            load_out_r <= 1'b0;
        end else begin
            load_out_r <= load_out_r;
        end
    end

    // Registered write port; wa/wd hold their last value between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_r     <= 1'b0;
            acc_sel_r <= 1'b0;
            wa_r      <= {AW{1'b0}};
            wd_r      <= {DW{1'b0}};
        end else if (retire_s) begin
            wen_r     <= 1'b1;
            acc_sel_r <= ret_to_rf_s;
            wa_r      <= ret_addr_s;
            wd_r      <= ret_data_s;
        end else begin
            wen_r     <= 1'b0;
            acc_sel_r <= 1'b0;
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wen         = wen_r;
    assign acc_sel     = acc_sel_r;
    assign wa          = wa_r;
    assign wd          = wd_r;
    assign stall       = (count_r == FULL_C);
    assign pending_acc = pending_acc_s;
    assign pending_rf  = pending_rf_s;
    assign err         = err_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.

module tb_regfile_wb_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, alu_to_rf;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_req, mem_to_rf;
    logic [AW-1:0] mem_addr;
    logic          mem_rdata_valid;
    logic [DW-1:0] mem_rdata;
    logic          wen, acc_sel, stall, pending_acc, err;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [7:0]    pending_rf;

    // 10 ns clock
    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_to_rf(alu_to_rf), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_req(mem_req), .mem_to_rf(mem_to_rf), .mem_addr(mem_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .wen(wen), .acc_sel(acc_sel), .wa(wa), .wd(wd),
        .stall(stall), .pending_acc(pending_acc), .pending_rf(pending_rf), .err(err)
    );

    typedef struct {
        logic          to_rf;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ready;
    } ent_t;

    ent_t          mq[$];
    bit            m_lo;
    logic          e_wen, e_sel, e_err;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_prf();
        logic [7:0] r = 8'h00;
        foreach (mq[i]) if (mq[i].to_rf) r[mq[i].addr] = 1'b1;
        return r;
    endfunction

    function automatic logic model_pacc();
        logic r = 1'b0;
        foreach (mq[i]) if (!mq[i].to_rf) r = 1'b1;
        return r;
    endfunction

    task automatic model_retire();
        e_wen = 1'b1;
        e_sel = mq[0].to_rf;
        e_wa  = mq[0].addr;
        e_wd  = mq[0].data;
        void'(mq.pop_front());
    endtask

    // One clock of the writeback rules, applied to the program-order queue.
    task automatic model_step(input logic rst, av, arf, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic mr, mrf, input logic [AW-1:0] ma,
                              input logic rv, input logic [DW-1:0] rd);
        int  sz0;
        bit  lo0, popped;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_lo = 0; e_wen = 0; e_sel = 0; e_wa = '0; e_wd = '0; e_err = 0;
            return;
        end
        sz0 = mq.size(); lo0 = m_lo; popped = 0;
        e_wen = 0; e_sel = 0;
        if (rv) begin
            if (lo0) begin
                foreach (mq[i]) if (!mq[i].ready) begin mq[i].data = rd; mq[i].ready = 1'b1; end
                m_lo = 0;
            end else e_err = 1;
        end
        if (sz0 > 0 && mq[0].ready) begin model_retire(); popped = 1; end
        if (av) begin
            if (mr) e_err = 1;
            if (sz0 < DEPTH || popped) begin
                e.to_rf = arf; e.addr = aa; e.data = ad; e.ready = 1'b1;
                mq.push_back(e);
                if (sz0 == 0) model_retire();
            end else e_err = 1;
        end else if (mr) begin
            if (lo0 && !rv) e_err = 1;
            else if (sz0 < DEPTH || popped) begin
                e.to_rf = mrf; e.addr = ma; e.data = '0; e.ready = 1'b0;
                mq.push_back(e);
                m_lo = 1;
            end else e_err = 1;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check at the next falling edge.
    task automatic step(input logic rst, av, arf, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic mr, mrf, input logic [AW-1:0] ma,
                        input logic rv, input logic [DW-1:0] rd);
        reset = rst; alu_valid = av; alu_to_rf = arf; alu_addr = aa; alu_data = ad;
        mem_req = mr; mem_to_rf = mrf; mem_addr = ma; mem_rdata_valid = rv; mem_rdata = rd;
        model_step(rst, av, arf, aa, ad, mr, mrf, ma, rv, rd);
        @(negedge clk);
        check_val("wen",         32'(wen),         32'(e_wen));
        check_val("acc_sel",     32'(acc_sel),     32'(e_sel));
        check_val("wa",          32'(wa),          32'(e_wa));
        check_val("wd",          32'(wd),          32'(e_wd));
        check_val("stall",       32'(stall),       32'(mq.size() == DEPTH));
        check_val("pending_acc", 32'(pending_acc), 32'(model_pacc()));
        check_val("pending_rf",  32'(pending_rf),  32'(model_prf()));
        check_val("err",         32'(err),         32'(e_err));
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, '0, 0, 0, '0, 0, '0);
    endtask

    task automatic alu(input logic arf, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        step(0, 1, arf, aa, ad, 0, 0, '0, 0, '0);
    endtask

    task automatic load(input logic mrf, input logic [AW-1:0] ma);
        step(0, 0, 0, '0, '0, 1, mrf, ma, 0, '0);
    endtask

    task automatic ret(input logic [DW-1:0] rd);
        step(0, 0, 0, '0, '0, 0, 0, '0, 1, rd);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 0; alu_to_rf = 0; alu_addr = '0; alu_data = '0;
        mem_req = 0; mem_to_rf = 0; mem_addr = '0; mem_rdata_valid = 0; mem_rdata = '0;
        m_lo = 0; e_wen = 0; e_sel = 0; e_wa = '0; e_wd = '0; e_err = 0;
        @(negedge clk);

        // Reset, idle, then single ALU write to acc
        do_reset();
        idle();
        check_val("t1_stall", 32'(stall), 32'd0);
        check_val("t1_err",   32'(err),   32'd0);
        alu(1'b0, 3'd0, 8'h5A);
        check_val("t1_wen", 32'(wen), 32'd1);
        check_val("t1_sel", 32'(acc_sel), 32'd0);
        check_val("t1_wd",  32'(wd), 32'h5A);

        // Load to rf[3] followed by ALU to acc; load data returns later
        idle();
        load(1'b1, 3'd3);
        alu(1'b0, 3'd0, 8'h11);
        check_val("t2_prf3", 32'(pending_rf), 32'h08);
        idle();
        idle();
        check_val("t2_prf3b", 32'(pending_rf), 32'h08);
        ret(8'hC3);
        check_val("t2_wen1", 32'(wen), 32'd1);
        check_val("t2_sel1", 32'(acc_sel), 32'd1);
        check_val("t2_wa1",  32'(wa), 32'd3);
        check_val("t2_wd1",  32'(wd), 32'hC3);
        idle();
        check_val("t2_wd2",  32'(wd), 32'h11);
        check_val("t2_sel2", 32'(acc_sel), 32'd0);
        idle();
        check_val("t2_wen3", 32'(wen), 32'd0);

        // Fill the queue behind an unreturned load, overflow, then drain
        do_reset();
        load(1'b0, 3'd0);
        alu(1'b1, 3'd1, 8'h21);
        alu(1'b1, 3'd2, 8'h22);
        alu(1'b0, 3'd0, 8'h23);
        check_val("t3_stall", 32'(stall), 32'd1);
        alu(1'b1, 3'd5, 8'h24);
        check_val("t3_err", 32'(err), 32'd1);
        ret(8'h99);
        check_val("t3_unstall", 32'(stall), 32'd0);
        check_val("t3_wd0", 32'(wd), 32'h99);
        idle(); idle(); idle(); idle();

        // ALU and load request together, then a stray data return
        do_reset();
        step(0, 1, 1'b1, 3'd6, 8'h66, 1, 1'b1, 3'd7, 0, '0);
        check_val("t4_wen", 32'(wen), 32'd1);
        check_val("t4_err", 32'(err), 32'd1);
        ret(8'h77);
        check_val("t4_nowrite", 32'(wen), 32'd0);

        // Reset mid-operation, then stale load data
        do_reset();
        load(1'b1, 3'd4);
        alu(1'b1, 3'd1, 8'h31);
        alu(1'b0, 3'd0, 8'h32);
        do_reset();
        check_val("t5_wen",  32'(wen), 32'd0);
        check_val("t5_prf",  32'(pending_rf), 32'd0);
        check_val("t5_pacc", 32'(pending_acc), 32'd0);
        ret(8'h55);
        check_val("t5_err",  32'(err), 32'd1);
        check_val("t5_wen2", 32'(wen), 32'd0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic rst_v, av, mr, rv;
            rst_v = ($urandom_range(0, 99) == 0);
            av    = ($urandom_range(0, 99) < 45);
            mr    = av ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 20);
            rv    = m_lo ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
            step(rst_v, av, 1'($urandom), 3'($urandom), 8'($urandom),
                 mr, 1'($urandom), 3'($urandom), rv, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
